// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: op codes, state encoding, widths.
package md_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle HI/LO multiply/divide unit with MTHI/MTLO writes.
// Define MD_DIV_EN to build the DIV/DIVU datapath; otherwise DIV/DIVU are ignored as undefined ops.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    state_e                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [2*DATA_W-1:0]     res, res_next;
    logic                    res_wr, res_wr_next;
    logic [DATA_W-1:0]       hi_next, lo_next;
    logic [2*DATA_W-1:0]     prod;
    logic [CNT_W-1:0]        op_cnt;
    logic                    accept;

    assign accept = start && !req && (state == IDLE);
    assign op_cnt = op[1] ? DIV_CNT : MULT_CNT;

    // Signed product uses sign-extended operands; unsigned uses zero-extended.
    always_comb begin
        if (op[0])
            prod = {32'b0, a} * {32'b0, b};
        else
            prod = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
    end

`ifdef MD_DIV_EN
    logic [DATA_W-1:0] quot, rem;

    // Most-negative / -1 overflows a signed divider, so it is pinned explicitly.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (b != '0) begin
            if (op[0]) begin
                quot = a / b;
                rem  = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                quot = a;
                rem  = '0;
            end else begin
                quot = 32'($signed(a) / $signed(b));
                rem  = 32'($signed(a) % $signed(b));
            end
        end
    end
`endif

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        res_next    = res;
        res_wr_next = res_wr;
        hi_next     = hi;
        lo_next     = lo;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            res_next    = prod;
                            res_wr_next = 1'b1;
                            cnt_next    = op_cnt;
                            state_next  = BUSY;
                        end
`ifdef MD_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            res_next    = {rem, quot};
                            res_wr_next = (b != '0);
                            cnt_next    = op_cnt;
                            state_next  = BUSY;
                        end
`endif
                        OP_MTHI: hi_next = a;
                        OP_MTLO: lo_next = a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    if (res_wr) begin
                        hi_next = res[63:32];
                        lo_next = res[31:0];
                    end
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            res    <= '0;
            res_wr <= 1'b0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            res    <= res_next;
            res_wr <= res_wr_next;
            busy   <= (state_next == BUSY);
            hi     <= hi_next;
            lo     <= lo_next;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus random traffic against a behavioural model.
module tb_md_unit;
    import md_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;
`ifdef MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, req;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;
    bit          p_valid;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .req(req), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_mul(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        sx = sgn ? longint'($signed(x)) : longint'({32'b0, x});
        sy = sgn ? longint'($signed(y)) : longint'({32'b0, y});
        return 64'(sx * sy);
    endfunction

    // Returns {remainder, quotient}: magnitude division with the sign applied afterwards.
    function automatic logic [63:0] model_div(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, mx, my, q, r;
        sx = sgn ? longint'($signed(x)) : longint'({32'b0, x});
        sy = sgn ? longint'($signed(y)) : longint'({32'b0, y});
        mx = (sx < 0) ? -sx : sx;
        my = (sy < 0) ? -sy : sy;
        q  = mx / my;
        if ((sx < 0) != (sy < 0)) q = -q;
        r  = sx - q * sy;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic model_edge(input logic s, input logic [2:0] o, input logic [31:0] x,
                              input logic [31:0] y, input logic r, input logic rst);
        logic [63:0] v;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; p_valid = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_valid) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (s && !r) begin
            if (o == OP_MULT || o == OP_MULTU) begin
                v = model_mul(o == OP_MULT, x, y);
                {p_hi, p_lo} = v; p_valid = 1; m_left = MC;
            end else if (DIV_EN && (o == OP_DIV || o == OP_DIVU)) begin
                p_valid = (y != 0);
                if (p_valid) begin
                    v = model_div(o == OP_DIV, x, y);
                    {p_hi, p_lo} = v;
                end
                m_left = DC;
            end else if (o == OP_MTHI) begin
                m_hi = x;
            end else if (o == OP_MTLO) begin
                m_lo = x;
            end
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive, advance model at the edge, sample 1 time unit later.
    task automatic cyc(input logic s, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic r, input logic rst);
        start = s; op = o; a = x; b = y; req = r; reset = rst;
        @(posedge clk);
        model_edge(s, o, x, y, r, rst);
        #1;
        chk1("busy", busy, m_left > 0);
        chk32("hi", hi, m_hi);
        chk32("lo", lo, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    logic [31:0] ra, rb;
    logic [2:0]  ro;

    initial begin
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; m_left = 0; p_valid = 0;
        start = 0; op = 0; a = 0; b = 0; req = 0; reset = 1;
        cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk32("reset_hi", hi, 32'h0);
        chk1("reset_busy", busy, 1'b0);

        // Signed multiply
        cyc(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        idle(MC);
        chk32("mult_hi", hi, 32'hFFFF_FFFF);
        chk32("mult_lo", lo, 32'hFFFF_FFFA);

        // Unsigned multiply; old hi/lo held during busy via per-cycle model checks
        cyc(1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        chk32("multu_hold_hi", hi, 32'hFFFF_FFFF);
        idle(MC);
        chk32("multu_hi", hi, 32'h0000_0001);
        chk32("multu_lo", lo, 32'hFFFF_FFFE);

        // Signed divide and divide-by-zero
        cyc(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(DC);
`ifdef MD_DIV_EN
        chk32("div_lo", lo, 32'hFFFF_FFFD);
        chk32("div_hi", hi, 32'hFFFF_FFFF);
`endif
        cyc(1'b1, OP_DIVU, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        idle(DC);
        cyc(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(DC);
`ifdef MD_DIV_EN
        chk32("divovf_lo", lo, 32'h8000_0000);
        chk32("divovf_hi", hi, 32'h0);
`endif

        // Flushed start, MTLO during busy, MTHI/MTLO when idle
        cyc(1'b1, OP_MULT, 32'd7, 32'd9, 1'b1, 1'b0);
        chk1("req_busy", busy, 1'b0);
        cyc(1'b1, OP_MTHI, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, OP_MTLO, 32'hCAFE_0002, 32'd0, 1'b0, 1'b0);
        chk32("mthi", hi, 32'hCAFE_0001);
        cyc(1'b1, OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b0);
        cyc(1'b1, OP_MTLO, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        chk32("mtlo_busy", lo, 32'hCAFE_0002);
        idle(MC);
        chk32("mtlo_busy_commit", lo, 32'd42);

        // Reset in the third busy cycle discards the pending result
        cyc(1'b1, OP_MULT, 32'd100, 32'd100, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_lo", lo, 32'h0);
        idle(MC + 2);
        chk32("rst_nocommit", lo, 32'h0);

        // Second start while busy, req asserted mid-operation
        cyc(1'b1, OP_MULTU, 32'd3, 32'd5, 1'b0, 1'b0);
        cyc(1'b1, OP_MULTU, 32'd11, 32'd11, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        idle(MC - 3);
        chk1("second_busy", busy, 1'b1);
        idle(1);
        chk32("second_lo", lo, 32'd15);

        // Undefined op codes
        cyc(1'b1, 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);
        cyc(1'b1, 3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000;
                1: ra = 32'($urandom_range(0, 20)) - 32'd10;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(0, 20)) - 32'd10;
                default: rb = $urandom;
            endcase
            cyc(1'($urandom_range(0, 2) == 0), ro, ra, rb,
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
